// File: rtl/adder_fp_param_if.sv
// Operand/result handshake bundle for the multi-cycle floating-point adder.
// The slave side is the adder; the master side supplies operands and consumes results.
interface adder_fp_param_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         valid_stb_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         sub_i;
  logic         valid_stb_o;
  logic [W-1:0] z_o;
  logic [2:0]   flags_o;
  logic         ack_z_i;

  modport slave (
    input  valid_stb_i, a_i, b_i, sub_i, ack_z_i,
    output ready_o, valid_stb_o, z_o, flags_o
  );

  modport master (
    output valid_stb_i, a_i, b_i, sub_i, ack_z_i,
    input  ready_o, valid_stb_o, z_o, flags_o
  );
endinterface

// File: rtl/adder_fp_param.sv
// Parameterised IEEE-754-style adder/subtractor, one pipeline step per FSM state,
// round-to-nearest-even, result held in OUT until the consumer acknowledges.
module adder_fp_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic            clk,
  input  logic            arst_n,
  adder_fp_param_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 4;   // hidden bit, fraction, guard, round, sticky
  localparam int EW = EXP_W + 1;   // one spare bit so exponent carries are visible
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0]     QNAN = {1'b1, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, OUT} state_e;

  state_e         state_q;
  logic           ready_q, start_q, valid_q;
  logic [W-1:0]   z_q;
  logic [2:0]     flags_q;
  logic           accept;

  logic [W-1:0]   a_q, b_q;
  logic           sub_q;
  logic           sa_q, sb_q, spec_q;
  logic [EXP_W-1:0] ea_q, eb_q;
  logic [MAN_W:0] ma_q, mb_q;
  logic [W-1:0]   spec_z_q;
  logic [2:0]     spec_f_q;
  logic [MW-1:0]  big_q, small_q, nm_q;
  logic [EW-1:0]  exp_q;
  logic           sign_q, eff_add_q, neg_zero_q;
  logic [MW:0]    sum_q;

  // UNPACK
  logic [EXP_W-1:0] ea_raw, eb_raw, ea_d, eb_d;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0]   ma_d, mb_d;
  logic             sa_d, sb_d, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
  logic             spec_d;
  logic [W-1:0]     spec_z_d;
  logic [2:0]       spec_f_d;

  // NOTE: every always_comb output gets a default at the top so no path leaves a latch behind.
  always_comb begin
    ea_raw   = a_q[W-2:MAN_W];
    eb_raw   = b_q[W-2:MAN_W];
    fa       = a_q[MAN_W-1:0];
    fb       = b_q[MAN_W-1:0];
    sa_d     = a_q[W-1];
    sb_d     = b_q[W-1] ^ sub_q;
    ea_d     = (ea_raw == '0) ? EXP_W'(1) : ea_raw;
    eb_d     = (eb_raw == '0) ? EXP_W'(1) : eb_raw;
    ma_d     = {ea_raw != '0, fa};
    mb_d     = {eb_raw != '0, fb};
    a_nan    = (ea_raw == EMAX) && (fa != '0);
    b_nan    = (eb_raw == EMAX) && (fb != '0);
    a_snan   = a_nan && !fa[MAN_W-1];
    b_snan   = b_nan && !fb[MAN_W-1];
    a_inf    = (ea_raw == EMAX) && (fa == '0);
    b_inf    = (eb_raw == EMAX) && (fb == '0);
    spec_d   = 1'b0;
    spec_z_d = '0;
    spec_f_d = '0;
    if (a_nan || b_nan) begin
      spec_d   = 1'b1;
      spec_z_d = QNAN;
      spec_f_d = {a_snan | b_snan, 2'b00};
    end else if (a_inf && b_inf && (sa_d != sb_d)) begin
      spec_d   = 1'b1;
      spec_z_d = QNAN;
      spec_f_d = 3'b100;
    end else if (a_inf) begin
      spec_d   = 1'b1;
      spec_z_d = {sa_d, EMAX, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spec_d   = 1'b1;
      spec_z_d = {sb_d, EMAX, {MAN_W{1'b0}}};
    end
  end

  // ALIGN: the larger magnitude keeps its exponent, the smaller is shifted under it
  logic             a_big, sign_d;
  logic [EXP_W-1:0] big_e, sml_e, shamt;
  logic [MAN_W:0]   big_m, sml_m;
  logic [MW-1:0]    sml_ext, shifted, big_d, small_d;
  logic             lost;
  logic [EW-1:0]    exp_al_d;

  always_comb begin
    a_big    = {ea_q, ma_q} >= {eb_q, mb_q};
    big_e    = a_big ? ea_q : eb_q;
    sml_e    = a_big ? eb_q : ea_q;
    big_m    = a_big ? ma_q : mb_q;
    sml_m    = a_big ? mb_q : ma_q;
    sign_d   = a_big ? sa_q : sb_q;
    shamt    = big_e - sml_e;
    sml_ext  = {sml_m, 3'b000};
    shifted  = sml_ext >> shamt;
    lost     = |(sml_ext & ~({MW{1'b1}} << shamt));
    big_d    = {big_m, 3'b000};
    exp_al_d = {1'b0, big_e};
    if (int'(shamt) >= MAN_W + 3) small_d = {{(MW-1){1'b0}}, |sml_m};
    else                          small_d = {shifted[MW-1:1], shifted[0] | lost};
  end

  // ADD: after alignment big_q >= small_q, so the difference never wraps
  logic [MW:0] sum_d;
  assign sum_d = eff_add_q ? ({1'b0, big_q} + {1'b0, small_q})
                           : ({1'b0, big_q} - {1'b0, small_q});

  // NORM: left shift is capped so the exponent bottoms out at 1 (subnormal range)
  int            norm_lz, norm_sh;
  logic [MW-1:0] nm_d;
  logic [EW-1:0] exp_nm_d;

  always_comb begin
    norm_lz = MW;
    for (int i = 0; i < MW; i++) if (sum_q[i]) norm_lz = MW - 1 - i;
    norm_sh = (norm_lz < int'(exp_q) - 1) ? norm_lz : int'(exp_q) - 1;
    if (sum_q[MW]) begin
      nm_d     = {sum_q[MW:2], sum_q[1] | sum_q[0]};
      exp_nm_d = exp_q + EW'(1);
    end else begin
      nm_d     = sum_q[MW-1:0] << norm_sh;
      exp_nm_d = exp_q - EW'(norm_sh);
    end
  end

  // ROUND
  logic [MAN_W:0]   rnd_mant, rnd_mant_f;
  logic [MAN_W+1:0] rnd_sum;
  logic [EW-1:0]    rnd_exp;
  logic             rnd_up, rnd_inx;
  logic [W-1:0]     z_d;
  logic [2:0]       flags_d;

  always_comb begin
    rnd_mant = nm_q[MW-1:3];
    rnd_inx  = nm_q[2] | nm_q[1] | nm_q[0];
    rnd_up   = nm_q[2] & (nm_q[1] | nm_q[0] | rnd_mant[0]);
    rnd_sum  = {1'b0, rnd_mant} + (MAN_W+2)'(rnd_up);
    rnd_exp  = exp_q;
    rnd_mant_f = rnd_sum[MAN_W:0];
    if (rnd_sum[MAN_W+1]) begin
      rnd_mant_f = rnd_sum[MAN_W+1:1];
      rnd_exp    = exp_q + EW'(1);
    end
    if (spec_q) begin
      z_d     = spec_z_q;
      flags_d = spec_f_q;
    end else if (rnd_exp >= {1'b0, EMAX}) begin
      z_d     = {sign_q, EMAX, {MAN_W{1'b0}}};
      flags_d = 3'b011;
    end else if (rnd_mant_f == '0) begin
      z_d     = {neg_zero_q, {(W-1){1'b0}}};
      flags_d = {2'b00, rnd_inx};
    end else begin
      z_d     = {sign_q, (rnd_mant_f[MAN_W] ? rnd_exp[EXP_W-1:0] : {EXP_W{1'b0}}),
                 rnd_mant_f[MAN_W-1:0]};
      flags_d = {2'b00, rnd_inx};
    end
  end

  // The accept edge only captures operands; IDLE then spends one cycle with ready low.
  assign accept = (state_q == IDLE) && ready_q && bus.valid_stb_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      z_q     <= '0;
      flags_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_q) begin
            start_q <= 1'b0;
            state_q <= UNPACK;
          end else if (accept) begin
            ready_q <= 1'b0;
            start_q <= 1'b1;
          end else begin
            ready_q <= 1'b1;
          end
        end
        UNPACK: state_q <= ALIGN;
        ALIGN:  state_q <= ADD;
        ADD:    state_q <= NORM;
        NORM:   state_q <= ROUND;
        ROUND: begin
          z_q     <= z_d;
          flags_q <= flags_d;
          valid_q <= 1'b1;
          state_q <= OUT;
        end
        OUT: begin
          if (bus.ack_z_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; the FSM guarantees they are written before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= bus.a_i;
      b_q   <= bus.b_i;
      sub_q <= bus.sub_i;
    end
    case (state_q)
      UNPACK: begin
        sa_q     <= sa_d;
        sb_q     <= sb_d;
        ea_q     <= ea_d;
        eb_q     <= eb_d;
        ma_q     <= ma_d;
        mb_q     <= mb_d;
        spec_q   <= spec_d;
        spec_z_q <= spec_z_d;
        spec_f_q <= spec_f_d;
      end
      ALIGN: begin
        big_q      <= big_d;
        small_q    <= small_d;
        exp_q      <= exp_al_d;
        sign_q     <= sign_d;
        eff_add_q  <= (sa_q == sb_q);
        neg_zero_q <= sa_q & sb_q;
      end
      ADD:  sum_q <= sum_d;
      NORM: begin
        nm_q  <= nm_d;
        exp_q <= exp_nm_d;
      end
      default: ;
    endcase
  end

  assign bus.ready_o     = ready_q;
  assign bus.valid_stb_o = valid_q;
  assign bus.z_o         = z_q;
  assign bus.flags_o     = flags_q;
endmodule

// File: tb/tb_adder_fp_param.sv
// Scoreboard bench for adder_fp_param at fp32 defaults: directed corner cases,
// exact integer sums, output hold under back-pressure and reset mid-operation.
module tb_adder_fp_param;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 1 + EXP_W + MAN_W;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  adder_fp_param_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  adder_fp_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [W-1:0] z;
    logic [2:0]   f;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fp_of_int(input int n);
    logic        s;
    logic [31:0] m;
    int          msb;
    if (n == 0) return 32'h0;
    s   = (n < 0);
    m   = s ? 32'(-n) : 32'(n);
    msb = 0;
    for (int i = 0; i < 32; i++) if (m[i]) msb = i;
    m = (m << (23 - msb)) & 32'h007F_FFFF;
    return {s, 8'(127 + msb), m[22:0]};
  endfunction

  // Starts and ends on a falling edge; hold > 0 keeps ack low that many cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic [W-1:0] ez, input logic [2:0] ef, input int hold);
    exp_t e;
    int   waited;
    int   lat;
    e.z = ez;
    e.f = ef;
    sb_q.push_back(e);
    waited = 0;
    while (bus.ready_o !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_op", 32'(bus.ready_o), 32'd1);
    bus.a_i = a;
    bus.b_i = b;
    bus.sub_i = sub;
    bus.valid_stb_i = 1'b1;
    @(negedge clk);
    bus.valid_stb_i = 1'b0;
    check("ready_low_after_accept", 32'(bus.ready_o), 32'd0);
    lat = 0;
    while (bus.valid_stb_o !== 1'b1 && lat < 30) begin
      bus.a_i = $urandom;
      bus.b_i = $urandom;
      bus.sub_i = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    check("latency", 32'(lat), 32'd6);
    check("z", bus.z_o, e.z);
    check("flags", 32'(bus.flags_o), 32'(e.f));
    if (hold > 0) begin
      bus.valid_stb_i = 1'b1;
      for (int i = 0; i < hold; i++) begin
        bus.a_i = $urandom;
        bus.b_i = $urandom;
        @(negedge clk);
        check("hold_z", bus.z_o, e.z);
        check("hold_flags", 32'(bus.flags_o), 32'(e.f));
        check("hold_valid", 32'(bus.valid_stb_o), 32'd1);
        check("hold_ready", 32'(bus.ready_o), 32'd0);
      end
    end
    bus.ack_z_i = 1'b1;
    bus.valid_stb_i = 1'b0;
    @(negedge clk);
    bus.ack_z_i = 1'b0;
    check("ready_after_ack", 32'(bus.ready_o), 32'd1);
    check("valid_after_ack", 32'(bus.valid_stb_o), 32'd0);
    if (hold > 0) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("no_extra_result", 32'(bus.valid_stb_o), 32'd0);
      end
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int  x, y, r;
    logic s;
    logic saw_valid;

    arst_n = 1'b0;
    bus.valid_stb_i = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    bus.sub_i = 1'b0;
    bus.ack_z_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.ready_o), 32'd0);
    check("rst_valid", 32'(bus.valid_stb_o), 32'd0);
    check("rst_z", bus.z_o, 32'd0);
    check("rst_flags", 32'(bus.flags_o), 32'd0);
    arst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.ready_o), 32'd1);

    run_op(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 3'b000, 0);
    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 3'b000, 0);
    run_op(32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'hFFC0_0000, 3'b100, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFC0_0000, 3'b000, 0);
    run_op(32'h7F80_0001, 32'h3F80_0000, 1'b0, 32'hFFC0_0000, 3'b100, 0);
    run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b011, 0);
    run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 3'b000, 0);
    run_op(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 3'b001, 0);
    run_op(32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 3'b001, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 3'b000, 0);
    run_op(32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 3'b000, 0);
    run_op(32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000, 3'b000, 0);
    run_op(32'h7F80_0000, 32'h3F80_0000, 1'b1, 32'h7F80_0000, 3'b000, 0);
    run_op(32'h0000_0000, 32'h4049_0FDB, 1'b0, 32'h4049_0FDB, 3'b000, 0);
    run_op(32'h4040_0000, 32'h4000_0000, 1'b1, 32'h3F80_0000, 3'b000, 0);

    // Exact integer sums: expected encoding is built independently from the integer result.
    for (int t = 0; t < 8; t++) begin
      x = int'($urandom_range(1, 100000));
      y = int'($urandom_range(1, 100000));
      if ($urandom_range(0, 1) == 1) x = -x;
      if ($urandom_range(0, 1) == 1) y = -y;
      s = 1'($urandom);
      r = s ? (x - y) : (x + y);
      run_op(fp_of_int(x), fp_of_int(y), s, fp_of_int(r), 3'b000, 0);
    end

    run_op(32'h4000_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 3'b000, 10);

    // Reset while the operation sits in ALIGN: no result may ever appear for it.
    bus.a_i = 32'h3F80_0000;
    bus.b_i = 32'h4000_0000;
    bus.sub_i = 1'b0;
    bus.valid_stb_i = 1'b1;
    @(negedge clk);
    bus.valid_stb_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 arst_n = 1'b0;
    #1;
    check("async_rst_ready", 32'(bus.ready_o), 32'd0);
    check("async_rst_valid", 32'(bus.valid_stb_o), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    check("ready_after_mid_rst", 32'(bus.ready_o), 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.valid_stb_o === 1'b1) saw_valid = 1'b1;
    end
    check("discarded_op", 32'(saw_valid), 32'd0);
    run_op(32'h4040_0000, 32'h3F80_0000, 1'b0, 32'h4080_0000, 3'b000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
